// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RISC-V style datapath.
// Fetch/decode/execute/memory/writeback sequencing with a per-access wait
// counter that converts a stalled memory access into a bus-error trap.
// Optional feature macro: CTRL_INSTRET_EN adds a 32-bit retired-instruction
// counter on output port instret.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALUOp,
  output logic [1:0] result_src,
  output logic       illegal_instr,
  output logic       bus_err,
  output logic [3:0] state
`ifdef CTRL_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       ill_q, ill_d;
  logic       berr_q, berr_d;
  logic [8:0] wcnt_inc;
  logic       expired;
  logic       in_wait, enter_wait;

  // One extra bit so the compare against WAIT_MAX cannot wrap.
  assign wcnt_inc   = {1'b0, wcnt_q} + 9'd1;
  assign expired    = (wcnt_inc >= 9'(WAIT_MAX));
  assign in_wait    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign enter_wait = (state_d != state_q) &&
                      ((state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR));

  // Next-state, wait counter and fault latch update.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ill_d   = ill_q;
    berr_d  = berr_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (expired) begin state_d = S_TRAP; berr_d = 1'b1; end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          default: begin state_d = S_TRAP; ill_d = 1'b1; end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      // Opcode is re-sampled here, not remembered from DECODE.
      S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) state_d = S_MEM_WB;
        else if (expired) begin state_d = S_TRAP; berr_d = 1'b1; end
      end
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
        else if (expired) begin state_d = S_TRAP; berr_d = 1'b1; end
      end
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALU_WB;
      S_TRAP: begin
        state_d = S_FETCH;
        ill_d   = 1'b0;
        berr_d  = 1'b0;
      end
      default:    state_d = S_FETCH;
    endcase
    if (in_wait && !mem_ready) wcnt_d = wcnt_inc[7:0];
    if (enter_wait) wcnt_d = '0;
  end

  // State and fault registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end

`ifdef CTRL_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q;
  assign retire = (state_q == S_ALU_WB) || (state_q == S_MEM_WB) || (state_q == S_BRANCH) ||
                  ((state_q == S_MEM_WR) && mem_ready);

  // Retired-instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!rst_n)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = rst_n ? instret_q : 32'd0;
`endif

  assign state = rst_n ? state_q : 4'd0;

  // Moore-style decode of control outputs; only FETCH also looks at mem_ready.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    ALUOp         = 2'b00;
    result_src    = 2'b00;
    illegal_instr = 1'b0;
    bus_err       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
          end
        end
        S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
        S_EXEC_R:   begin alu_src_a = 2'b10; ALUOp = 2'b10; end
        S_EXEC_I:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; ALUOp = 2'b10; end
        S_ALU_WB:   reg_write = 1'b1;
        S_MEM_ADDR: begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
        S_MEM_RD:   begin mem_req = 1'b1; mem_src = 1'b1; end
        S_MEM_WB:   begin reg_write = 1'b1; result_src = 2'b01; end
        S_MEM_WR:   begin mem_req = 1'b1; mem_we = 1'b1; mem_src = 1'b1; end
        S_BRANCH:   begin alu_src_a = 2'b10; ALUOp = 2'b01; pc_write_cond = 1'b1; end
        S_JAL:      begin pc_write = 1'b1; alu_src_a = 2'b01; alu_src_b = 2'b10; end
        S_TRAP:     begin illegal_instr = ill_q; bus_err = berr_q; end
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level model expands each directed
// instruction into its expected per-cycle control vector; one loop drives
// the vectors and compares every cycle, then a short literal-pinned pass.
module tb_multicycle_ctrl;

  localparam int WM = 15;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JL = 7'b1101111;

  typedef struct packed {
    logic [3:0] st;
    logic       req, we, src, irw, pcw, pcwc, rw;
    logic [1:0] a, b, op, rs;
    logic       ill, be;
  } out_t;

  typedef struct {
    bit          rst;
    logic [6:0]  opc;
    bit          mr;
    out_t        o;
    int unsigned ir;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_src, ir_write, pc_write, pc_write_cond, reg_write;
  logic [1:0] alu_src_a, alu_src_b, ALUOp, result_src;
  logic       illegal_instr, bus_err;
  logic [3:0] state;
`ifdef CTRL_INSTRET_EN
  logic [31:0] instret;
`endif

  multicycle_ctrl #(.WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_src(mem_src),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ALUOp(ALUOp), .result_src(result_src), .illegal_instr(illegal_instr),
    .bus_err(bus_err), .state(state)
`ifdef CTRL_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  out_t dut_o;
  assign dut_o = {state, mem_req, mem_we, mem_src, ir_write, pc_write, pc_write_cond,
                  reg_write, alu_src_a, alu_src_b, ALUOp, result_src, illegal_instr, bus_err};

  int total = 0;
  int bad = 0;

  // ---------------- instruction-level model ----------------
  ent_t        q[$];
  int unsigned m_ret = 0;
  logic [6:0]  cur_op = '0;
  bit          noise = 1'b0;

  function automatic out_t z(input logic [3:0] st);
    out_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic push(input out_t o, input bit mr);
    ent_t e;
    e.rst = 1'b1; e.opc = cur_op; e.mr = mr; e.o = o; e.ir = m_ret;
    q.push_back(e);
  endtask

  task automatic p_reset(input int n);
    ent_t e;
    m_ret = 0;
    for (int i = 0; i < n; i++) begin
      e.rst = 1'b0; e.opc = cur_op; e.mr = noise; e.o = '0; e.ir = 0;
      q.push_back(e);
    end
  endtask

  task automatic p_fetch(input int waits);
    out_t o;
    for (int i = 0; i < waits; i++) begin
      o = z(4'd0); o.req = 1'b1; push(o, 1'b0);
    end
    o = z(4'd0); o.req = 1'b1; o.irw = 1'b1; o.pcw = 1'b1; o.b = 2'b10; o.rs = 2'b10;
    push(o, 1'b1);
  endtask

  task automatic p_decode();
    out_t o;
    o = z(4'd1); o.a = 2'b01; o.b = 2'b01; push(o, noise);
  endtask

  task automatic p_trap(input bit ill, input bit be);
    out_t o;
    o = z(4'd11); o.ill = ill; o.be = be; push(o, noise);
  endtask

  task automatic p_alu_wb();
    out_t o;
    o = z(4'd4); o.rw = 1'b1; push(o, noise);
    m_ret++;
  endtask

  task automatic p_mem_addr();
    out_t o;
    o = z(4'd5); o.a = 2'b10; o.b = 2'b01; push(o, noise);
  endtask

  task automatic i_alu(input logic [6:0] op, input int fw);
    out_t o;
    cur_op = op;
    p_fetch(fw); p_decode();
    o = z(op == OP_R ? 4'd2 : 4'd3); o.a = 2'b10; o.op = 2'b10;
    o.b = (op == OP_R) ? 2'b00 : 2'b01;
    push(o, noise);
    p_alu_wb();
  endtask

  task automatic i_load(input int fw, input int mw);
    out_t o;
    cur_op = OP_LD;
    p_fetch(fw); p_decode(); p_mem_addr();
    o = z(4'd6); o.req = 1'b1; o.src = 1'b1;
    for (int i = 0; i < mw; i++) push(o, 1'b0);
    push(o, 1'b1);
    o = z(4'd7); o.rw = 1'b1; o.rs = 2'b01; push(o, noise);
    m_ret++;
  endtask

  // mw < 0 means memory never answers: a bus-error trap follows WM wait cycles.
  task automatic i_store(input int fw, input int mw);
    out_t o;
    cur_op = OP_ST;
    p_fetch(fw); p_decode(); p_mem_addr();
    o = z(4'd8); o.req = 1'b1; o.we = 1'b1; o.src = 1'b1;
    if (mw < 0) begin
      for (int i = 0; i < WM; i++) push(o, 1'b0);
      p_trap(1'b0, 1'b1);
    end else begin
      for (int i = 0; i < mw; i++) push(o, 1'b0);
      push(o, 1'b1);
      m_ret++;
    end
  endtask

  task automatic i_store_reset(input int k);
    out_t o;
    cur_op = OP_ST;
    p_fetch(0); p_decode(); p_mem_addr();
    o = z(4'd8); o.req = 1'b1; o.we = 1'b1; o.src = 1'b1;
    for (int i = 0; i < k; i++) push(o, 1'b0);
    p_reset(1);
  endtask

  task automatic i_branch(input int fw);
    out_t o;
    cur_op = OP_BR;
    p_fetch(fw); p_decode();
    o = z(4'd9); o.a = 2'b10; o.op = 2'b01; o.pcwc = 1'b1; push(o, noise);
    m_ret++;
  endtask

  task automatic i_jal(input int fw);
    out_t o;
    cur_op = OP_JL;
    p_fetch(fw); p_decode();
    o = z(4'd10); o.pcw = 1'b1; o.a = 2'b01; o.b = 2'b10; push(o, noise);
    p_alu_wb();
  endtask

  task automatic i_illegal(input logic [6:0] op);
    cur_op = op;
    p_fetch(0); p_decode(); p_trap(1'b1, 1'b0);
  endtask

  task automatic i_fetch_timeout();
    out_t o;
    o = z(4'd0); o.req = 1'b1;
    for (int i = 0; i < WM; i++) push(o, 1'b0);
    p_trap(1'b0, 1'b1);
  endtask

  // ---------------- literal pass helpers ----------------
  task automatic step(input bit r, input logic [6:0] op, input bit mr);
    @(posedge clk); #1;
    rst_n = r; opcode = op; mem_ready = mr;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  initial begin
    int lit_st[5];
    int lit_rw[5];
    int ill_st[4];
    int ill_p[4];

    // Build the directed program.
    p_reset(2);
    i_alu(OP_R, 0);
    noise = 1'b1;
    i_alu(OP_I, 2);
    i_load(0, 3);
    i_store(1, 0);
    i_store(0, WM - 1);
    i_store(0, -1);
    i_branch(0);
    i_jal(1);
    i_illegal(7'b1111111);
    i_illegal(7'b0110111);
    i_fetch_timeout();
    i_alu(OP_R, 0);
    i_store_reset(2);
    i_alu(OP_R, 0);
    i_load(1, 0);

    // Drive and check every cycle.
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      rst_n = q[i].rst; opcode = q[i].opc; mem_ready = q[i].mr;
      @(negedge clk);
      total++;
      if (dut_o !== q[i].o) begin
        bad++;
        $display("FAIL vec%0d outputs got=%h want=%h", i, dut_o, q[i].o);
      end
`ifdef CTRL_INSTRET_EN
      total++;
      if (instret !== q[i].ir) begin
        bad++;
        $display("FAIL vec%0d instret got=%0d want=%0d", i, instret, q[i].ir);
      end
`endif
    end

    // Literal-pinned pass: R-type after reset, then an illegal opcode.
    lit_st = '{0, 1, 2, 4, 0};
    lit_rw = '{0, 0, 0, 1, 0};
    step(1'b0, OP_R, 1'b0);
    chk("reset_mem_req", int'(mem_req), 0);
    step(1'b0, OP_R, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, OP_R, 1'b1);
      chk("rtype_state", int'(state), lit_st[i]);
      chk("rtype_reg_write", int'(reg_write), lit_rw[i]);
      if (i == 2) chk("rtype_aluop", int'(ALUOp), 2);
    end
`ifdef CTRL_INSTRET_EN
    chk("rtype_instret", int'(instret), 1);
`endif
    ill_st = '{1, 11, 0, 0};
    ill_p  = '{0, 1, 0, 0};
    // Current cycle is FETCH with mem_ready=1 already applied.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 7'b1111111, 1'b0);
      chk("illegal_state", int'(state), ill_st[i]);
      chk("illegal_pulse", int'(illegal_instr), ill_p[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
